uart_program_loader: RTL
========================

Name: uart_program_loader

Overview:
Consumes the 32-bit words and word_end strobes from the UART word receiver and turns them into instruction-memory writes plus CPU reset control. It sits between the UART word receiver and the instruction memory / RISC-V core reset, and implements the LOAD / RUN / HALT boot protocol. While loading, it holds the core in reset and streams words into consecutive word addresses.

Parameters:
ADDR_W, 10, instruction-memory word-address width
DEPTH, 1024, instruction-memory capacity in words; the maximum accepted load count
TIMEOUT_CYCLES, 50000000, idle cycles allowed between words while loading before the load is aborted

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
instr  in  32  word from the UART receiver; command words carry the code in [7:0] with [31:8]=0
word_end  in  1  word-complete flag from the receiver; high for 2 consecutive cycles per word
mem_we  out  1  instruction-memory write strobe, 1-cycle pulse
mem_addr  out  ADDR_W  instruction-memory word address
mem_wdata  out  32  instruction-memory write data
cpu_rst  out  1  core reset, active-high
busy  out  1  high in GET_COUNT or LOAD
load_done  out  1  1-cycle pulse when a load completes
err  out  2  sticky error code: 0 none, 1 bad command, 2 overflow, 3 timeout

Behaviour:
- Reset values: mem_we=0, mem_addr=0, mem_wdata=0, cpu_rst=1, busy=0, load_done=0, err=0, state=IDLE, timeout counter=0.
- Word acceptance: register word_end into wend_q. The accept strobe is acc = word_end & ~wend_q (rising edge), so each word is accepted exactly once even though word_end is high for 2 cycles. Sample instr combinationally in the acc cycle.
- Latency: mem_we, mem_addr and mem_wdata are registered outputs and assert 1 cycle after acc.
- Command codes (instr[7:0], valid in IDLE and RUN): 0x01 LOAD, 0x02 RUN, 0x03 HALT.
- IDLE:
  - LOAD: clear err, set cpu_rst=1, go to GET_COUNT.
  - RUN: set cpu_rst=0, go to RUN.
  - HALT: set cpu_rst=1, stay in IDLE.
  - Any other code: set err=1, stay in IDLE.
- GET_COUNT: the accepted word is N (full 32 bits).
  - N=0: pulse load_done, go to IDLE.
  - N>DEPTH: set err=2, go to IDLE, no write.
  - Otherwise: remaining=N, next address=0, go to LOAD.
- LOAD: each acc writes instr to the current address (one mem_we pulse), increments the address and decrements remaining. When the last word is accepted (remaining=1), pulse load_done in the same cycle as its mem_we and go to IDLE. Because N<=DEPTH, the address never wraps.
- RUN: HALT sets cpu_rst=1 and goes to IDLE. Every other word is ignored and leaves err unchanged. cpu_rst stays 0 while in RUN.
- Timeout:
  - The counter runs only in GET_COUNT and LOAD, clears on every acc, and is held at 0 in other states.
  - When the counter reaches TIMEOUT_CYCLES-1 without an acc: set err=3, go to IDLE, keep cpu_rst=1.
  - If acc and expiry fall in the same cycle, acc wins and the counter clears.
- busy is a combinational decode of the state.
- Memory writes already performed before an overflow or timeout are not rolled back.
- Reset mid-load: return immediately to reset values. No further mem_we is issued and cpu_rst returns to 1.
- A word_end held high longer than 2 cycles still produces a single acc.

Decomposition:
- Package uart_loader_pkg contains:
  - state encodings IDLE/GET_COUNT/LOAD/RUN (2 bits)
  - command codes CMD_LOAD=8'h01, CMD_RUN=8'h02, CMD_HALT=8'h03
  - error codes ERR_NONE/ERR_CMD/ERR_OVF/ERR_TMO
- Sub-module word_strobe_det produces acc: a 1-flop rising-edge detector with synchronous reset. Everything else lives in a single FSM/datapath module.

Test Plan:
1. Reset, then word 0x00000001 (LOAD), N=3, then 0x00000013, 0x00100093, 0x00208133 -> three mem_we pulses at addr 0,1,2 with those data; load_done pulses with the third write; busy falls afterwards; cpu_rst stays 1; err=0.
2. After test 1, word 0x00000002 (RUN) -> cpu_rst=0 one cycle after acc. Then 0x00000001 -> ignored and cpu_rst stays 0. Then 0x00000003 -> cpu_rst=1 and state returns to IDLE.
3. LOAD, then N=1025 with DEPTH=1024 -> err=2, no mem_we, back in IDLE. A subsequent LOAD clears err to 0.
4. With TIMEOUT_CYCLES=100: LOAD, N=4, two data words, then silence -> err=3 exactly 100 cycles after the last acc, busy=0, only 2 writes performed. In a second run, a word arriving exactly on the expiry cycle is written and no error is flagged.
5. word_end held high for 2 cycles and then for 5 cycles per word -> exactly one write per word; address increments by 1 each time.
6. Assert reset between the 2nd and 3rd data words of an N=4 load -> all outputs return to reset values and no further writes occur. Also: word 0x00000007 in IDLE -> err=1.

Source files
------------

// File: rtl/uart_loader_pkg.sv
// rtl/uart_loader_pkg.sv - shared states, command codes and error codes for the UART program loader
package uart_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_GET_COUNT = 2'd1,
        ST_LOAD      = 2'd2,
        ST_RUN       = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE = 2'd0,
        ERR_CMD  = 2'd1,
        ERR_OVF  = 2'd2,
        ERR_TMO  = 2'd3
    } err_e;

    localparam logic [7:0] CMD_LOAD = 8'h01;
    localparam logic [7:0] CMD_RUN  = 8'h02;
    localparam logic [7:0] CMD_HALT = 8'h03;

endpackage

// File: rtl/word_strobe_det.sv
// rtl/word_strobe_det.sv - one-cycle accept strobe on the rising edge of word_end
module word_strobe_det (
    input  logic clk,
    input  logic reset,
    input  logic word_end_i,
    output logic acc_o
);

    logic wend_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            wend_q <= 1'b0;
        end else begin
            wend_q <= word_end_i;
        end
    end

    assign acc_o = word_end_i & ~wend_q;

endmodule

// File: rtl/uart_program_loader.sv
// rtl/uart_program_loader.sv - LOAD/RUN/HALT boot protocol driving instruction-memory writes and core reset
module uart_program_loader
    import uart_loader_pkg::*;
#(
    parameter int ADDR_W         = 10,
    parameter int DEPTH          = 1024,
    parameter int TIMEOUT_CYCLES = 50000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       instr,
    input  logic              word_end,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_rst,
    output logic              busy,
    output logic              load_done,
    output logic [1:0]        err
);

    localparam int REM_W = $clog2(DEPTH + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic acc;

    word_strobe_det u_strobe (
        .clk        (clk),
        .reset      (reset),
        .word_end_i (word_end),
        .acc_o      (acc)
    );

    state_e            state_q, state_d;
    err_e              err_q, err_d;
    logic [TMO_W-1:0]  cnt_q, cnt_d;
    logic [REM_W-1:0]  rem_q, rem_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              cpu_rst_q, cpu_rst_d;
    logic              load_done_q, load_done_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            err_q       <= ERR_NONE;
            cnt_q       <= '0;
            rem_q       <= '0;
            ptr_q       <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_rst_q   <= 1'b1;
            load_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            ptr_q       <= ptr_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_rst_q   <= cpu_rst_d;
            load_done_q <= load_done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        err_d       = err_q;
        cnt_d       = '0;
        rem_d       = rem_q;
        ptr_d       = ptr_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cpu_rst_d   = cpu_rst_q;
        load_done_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (acc) begin
                    case (instr[7:0])
                        CMD_LOAD: begin
                            err_d     = ERR_NONE;
                            cpu_rst_d = 1'b1;
                            state_d   = ST_GET_COUNT;
                        end
                        CMD_RUN: begin
                            cpu_rst_d = 1'b0;
                            state_d   = ST_RUN;
                        end
                        CMD_HALT: cpu_rst_d = 1'b1;
                        default:  err_d = ERR_CMD;
                    endcase
                end
            end

            ST_GET_COUNT: begin
                if (acc) begin
                    if (instr == 32'd0) begin
                        load_done_d = 1'b1;
                        state_d     = ST_IDLE;
                    end else if (instr > 32'(DEPTH)) begin
                        err_d   = ERR_OVF;
                        state_d = ST_IDLE;
                    end else begin
                        rem_d   = instr[REM_W-1:0];
                        ptr_d   = '0;
                        state_d = ST_LOAD;
                    end
                end else if (cnt_q == TMO_LAST) begin
                    err_d   = ERR_TMO;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + TMO_W'(1);
                end
            end

            ST_LOAD: begin
                if (acc) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = ptr_q;
                    mem_wdata_d = instr;
                    ptr_d       = ptr_q + ADDR_W'(1);
                    rem_d       = rem_q - REM_W'(1);
                    // The final word completes the load in the same cycle as its write.
                    if (rem_q == REM_W'(1)) begin
                        load_done_d = 1'b1;
                        state_d     = ST_IDLE;
                    end
                end else if (cnt_q == TMO_LAST) begin
                    err_d   = ERR_TMO;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + TMO_W'(1);
                end
            end

            ST_RUN: begin
                if (acc && instr[7:0] == CMD_HALT) begin
                    cpu_rst_d = 1'b1;
                    state_d   = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    assign busy      = (state_q == ST_GET_COUNT) || (state_q == ST_LOAD);
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_rst   = cpu_rst_q;
    assign load_done = load_done_q;
    assign err       = err_q;

endmodule
